jtag_dmi_access: RTL and testbench

//  DMI access register (RISC-V debug spec "dmi", IR 0x11) on BSCANE2 user chain 3, alongside the

---
 rtl/jtag_dmi_access.sv | 148 ++++++++++++++
 tb/tb_jtag_dmi_access.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dmi_access.sv
// RISC-V debug DMI access register on a BSCANE2 user chain. It shifts {addr,data,op} in from the
// debugger, issues one DM request, and returns the read data plus a sticky op status.
module jtag_dmi_access #(
    parameter int ABITS  = 7,
    parameter int DATA_W = 32
) (
    input  logic              jtag_tck,
    input  logic              jtag_trst_n,
    input  logic              jtag_sel,
    input  logic              jtag_capture,
    input  logic              jtag_shift,
    input  logic              jtag_update,
    input  logic              jtag_tdi,
    output logic              jtag_tdo,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic [1:0]        dmi_stat,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [ABITS-1:0]  dmi_req_addr,
    output logic [DATA_W-1:0] dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_rsp_valid,
    input  logic [DATA_W-1:0] dmi_rsp_data,
    input  logic [1:0]        dmi_rsp_resp
);

    localparam int DR_W = ABITS + DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            state;
    logic [DR_W-1:0]   sr;
    logic [1:0]        sticky;
    logic [1:0]        sticky_eff;
    logic [1:0]        sticky_next;
    logic [1:0]        cap_op;
    logic [DATA_W-1:0] rdata;
    logic [ABITS-1:0]  last_addr;
    logic              update_accept;

    logic [ABITS-1:0]  sr_addr;
    logic [DATA_W-1:0] sr_data;
    logic [1:0]        sr_op;

    assign sr_addr = sr[DR_W-1:DATA_W+2];
    assign sr_data = sr[DATA_W+1:2];
    assign sr_op   = sr[1:0];

    assign jtag_tdo = jtag_sel ? sr[0] : jtag_tdi;
    assign dmi_stat = sticky;

    // The status clear from dtmcs lands before the update is decoded, so a clear in the same
    // cycle as an update lets that update through; capture reports the pre-clear status.
    always_comb begin
        sticky_eff = (dmi_reset || dmi_hard_reset) ? 2'd0 : sticky;

        if (sticky != 2'd0)
            cap_op = sticky;
        else if (state != S_IDLE)
            cap_op = 2'd3;
        else
            cap_op = 2'd0;

        update_accept = jtag_sel && jtag_update && !dmi_hard_reset &&
                        (sticky_eff == 2'd0) && (state == S_IDLE) &&
                        ((sr_op == 2'd1) || (sr_op == 2'd2));

        sticky_next = sticky_eff;
        if (!dmi_hard_reset) begin
            if (jtag_sel && jtag_capture && (state != S_IDLE) && (sticky == 2'd0))
                sticky_next = 2'd3;
            if (jtag_sel && jtag_update && (state != S_IDLE) && (sticky_next == 2'd0))
                sticky_next = 2'd3;
            // Busy from a same-cycle update takes precedence; resp 1 is reported as failed.
            if ((state == S_WAIT) && dmi_rsp_valid && (sticky_next == 2'd0)) begin
                if (dmi_rsp_resp == 2'd3)
                    sticky_next = 2'd3;
                else if (dmi_rsp_resp != 2'd0)
                    sticky_next = 2'd2;
            end
        end
    end

    // Shift register, request FSM and status; a hard reset aborts the transaction but keeps
    // the shift register, read data and last address so the debugger can still inspect them.
    always_ff @(posedge jtag_tck or posedge jtag_trst_n) begin
        if (jtag_trst_n) begin
            state         <= S_IDLE;
            sr            <= '0;
            sticky        <= 2'd0;
            rdata         <= '0;
            last_addr     <= '0;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= 2'd0;
        end else begin
            sticky <= sticky_next;

            if (jtag_sel) begin
                if (jtag_capture)
                    sr <= {last_addr, rdata, cap_op};
                else if (jtag_shift)
                    sr <= {jtag_tdi, sr[DR_W-1:1]};
            end

            if (dmi_hard_reset) begin
                state         <= S_IDLE;
                dmi_req_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (update_accept) begin
                            dmi_req_addr  <= sr_addr;
                            dmi_req_data  <= sr_data;
                            dmi_req_op    <= sr_op;
                            last_addr     <= sr_addr;
                            dmi_req_valid <= 1'b1;
                            state         <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (dmi_req_ready) begin
                            dmi_req_valid <= 1'b0;
                            state         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (dmi_rsp_valid) begin
                            rdata <= dmi_rsp_data;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        dmi_req_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_dmi_access.sv
// Self-checking bench for jtag_dmi_access: directed DMI scenarios plus randomized transactions,
// compared against a per-scan transaction model of the DMI register.
module tb_jtag_dmi_access;

    localparam int ABITS  = 7;
    localparam int DATA_W = 32;
    localparam int DR_W   = ABITS + DATA_W + 2;

    logic              jtag_tck = 1'b0;
    logic              jtag_trst_n = 1'b1;
    logic              jtag_sel = 1'b0;
    logic              jtag_capture = 1'b0;
    logic              jtag_shift = 1'b0;
    logic              jtag_update = 1'b0;
    logic              jtag_tdi = 1'b0;
    logic              jtag_tdo;
    logic              dmi_reset = 1'b0;
    logic              dmi_hard_reset = 1'b0;
    logic [1:0]        dmi_stat;
    logic              dmi_req_valid;
    logic              dmi_req_ready = 1'b0;
    logic [ABITS-1:0]  dmi_req_addr;
    logic [DATA_W-1:0] dmi_req_data;
    logic [1:0]        dmi_req_op;
    logic              dmi_rsp_valid = 1'b0;
    logic [DATA_W-1:0] dmi_rsp_data = '0;
    logic [1:0]        dmi_rsp_resp = 2'd0;

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int m_hs = 0;

    // Transaction-level model: one pending flag instead of the DUT's REQ/WAIT split.
    logic [1:0]        m_sticky = 2'd0;
    bit                m_pending = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [ABITS-1:0]  m_last_addr = '0;
    logic [ABITS-1:0]  m_req_addr = '0;

    jtag_dmi_access #(.ABITS(ABITS), .DATA_W(DATA_W)) dut (
        .jtag_tck(jtag_tck), .jtag_trst_n(jtag_trst_n), .jtag_sel(jtag_sel),
        .jtag_capture(jtag_capture), .jtag_shift(jtag_shift), .jtag_update(jtag_update),
        .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo), .dmi_reset(dmi_reset),
        .dmi_hard_reset(dmi_hard_reset), .dmi_stat(dmi_stat), .dmi_req_valid(dmi_req_valid),
        .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data),
        .dmi_req_op(dmi_req_op), .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data),
        .dmi_rsp_resp(dmi_rsp_resp)
    );

    always #5 jtag_tck = ~jtag_tck;

    always @(posedge jtag_tck)
        if (!jtag_trst_n && dmi_req_valid && dmi_req_ready)
            hs_count <= hs_count + 1;

    task automatic tick();
        @(posedge jtag_tck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit do_cap, input logic [DR_W-1:0] din, output logic [DR_W-1:0] dout);
        dout = '0;
        jtag_sel = 1'b1;
        if (do_cap) begin
            jtag_capture = 1'b1;
            tick();
            jtag_capture = 1'b0;
        end
        jtag_shift = 1'b1;
        for (int i = 0; i < DR_W; i++) begin
            jtag_tdi = din[i];
            #1 dout[i] = jtag_tdo;
            tick();
        end
        jtag_shift  = 1'b0;
        jtag_update = 1'b1;
        tick();
        jtag_update = 1'b0;
        jtag_sel    = 1'b0;
    endtask

    task automatic model_capture(output logic [DR_W-1:0] expv);
        logic [1:0] op;
        if (m_sticky != 2'd0)
            op = m_sticky;
        else if (m_pending)
            op = 2'd3;
        else
            op = 2'd0;
        expv = {m_last_addr, m_rdata, op};
        if (m_pending && m_sticky == 2'd0)
            m_sticky = 2'd3;
    endtask

    task automatic model_update(input logic [DR_W-1:0] din, output bit acc);
        logic [1:0] op;
        op  = din[1:0];
        acc = 1'b0;
        if (m_sticky != 2'd0) begin
        end else if (m_pending) begin
            m_sticky = 2'd3;
        end else if (op == 2'd1 || op == 2'd2) begin
            acc         = 1'b1;
            m_pending   = 1'b1;
            m_last_addr = din[DR_W-1:DATA_W+2];
            m_req_addr  = din[DR_W-1:DATA_W+2];
        end
    endtask

    task automatic run_scan(input bit do_cap, input logic [ABITS-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [1:0] op, input string tag);
        logic [DR_W-1:0] din, dout, expv;
        bit acc;
        din  = {addr, data, op};
        expv = '0;
        if (do_cap)
            model_capture(expv);
        applyStimulus(do_cap, din, dout);
        if (do_cap)
            checkOutput({tag, "_cap"}, dout, expv);
        model_update(din, acc);
        checkOutput({tag, "_stat"}, dmi_stat, m_sticky);
        checkOutput({tag, "_valid"}, dmi_req_valid, acc);
        if (acc) begin
            checkOutput({tag, "_addr"}, dmi_req_addr, addr);
            checkOutput({tag, "_data"}, dmi_req_data, data);
            checkOutput({tag, "_op"}, dmi_req_op, op);
        end
    endtask

    task automatic dm_handshake(input int delay);
        for (int i = 0; i < delay; i++) begin
            checkOutput("hold_valid", dmi_req_valid, 1);
            checkOutput("hold_addr", dmi_req_addr, m_req_addr);
            tick();
        end
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
        m_hs++;
        checkOutput("hs_valid_drop", dmi_req_valid, 0);
    endtask

    task automatic dm_respond(input logic [DATA_W-1:0] data, input logic [1:0] resp);
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = data;
        dmi_rsp_resp  = resp;
        tick();
        dmi_rsp_valid = 1'b0;
        if (m_pending) begin
            m_rdata = data;
            if (m_sticky == 2'd0) begin
                if (resp == 2'd3)
                    m_sticky = 2'd3;
                else if (resp != 2'd0)
                    m_sticky = 2'd2;
            end
            m_pending = 1'b0;
        end
    endtask

    task automatic pulse_dmi_reset();
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        m_sticky = 2'd0;
        checkOutput("dmi_reset_stat", dmi_stat, 0);
    endtask

    initial begin
        logic [1:0]        r_op;
        logic [ABITS-1:0]  r_addr;
        logic [DATA_W-1:0] r_data;

        jtag_tdi = 1'b1;
        #12;
        checkOutput("rst_valid", dmi_req_valid, 0);
        checkOutput("rst_stat", dmi_stat, 0);
        checkOutput("rst_req_op", dmi_req_op, 0);
        checkOutput("rst_tdo_bypass", jtag_tdo, 1);
        jtag_tdi = 1'b0;
        jtag_trst_n = 1'b0;
        tick();

        $display("[TB] write 0x10");
        run_scan(1, 7'h10, 32'hDEADBEEF, 2'd2, "wr");
        dm_handshake(3);
        dm_respond(32'h0, 2'd0);
        run_scan(1, 7'h00, 32'h0, 2'd0, "wr_after");

        $display("[TB] read 0x11");
        run_scan(1, 7'h11, 32'h0, 2'd1, "rd");
        dm_handshake(1);
        dm_respond(32'h12345678, 2'd0);
        run_scan(1, 7'h00, 32'h0, 2'd0, "rd_after");

        $display("[TB] op while busy");
        run_scan(1, 7'h22, 32'hA5A5A5A5, 2'd2, "busy_first");
        dm_handshake(0);
        run_scan(1, 7'h23, 32'h11111111, 2'd2, "busy_cap");
        pulse_dmi_reset();
        run_scan(0, 7'h24, 32'h22222222, 2'd1, "busy_upd");
        dm_respond($urandom, 2'd0);
        checkOutput("busy_hs", hs_count, m_hs);
        pulse_dmi_reset();
        run_scan(1, 7'h25, 32'h33333333, 2'd1, "busy_next");
        dm_handshake(2);
        dm_respond($urandom, 2'd0);

        $display("[TB] failed response");
        run_scan(1, 7'h30, 32'h0, 2'd1, "fail_rd");
        dm_handshake(0);
        dm_respond($urandom, 2'd2);
        checkOutput("fail_stat", dmi_stat, 2);
        run_scan(1, 7'h31, $urandom, 2'd2, "fail_ignored");
        run_scan(1, 7'h32, $urandom, 2'd0, "fail_nop");
        checkOutput("fail_hs", hs_count, m_hs);
        pulse_dmi_reset();
        run_scan(1, 7'h33, $urandom, 2'd0, "nop_clean");

        $display("[TB] hard reset in REQ");
        run_scan(1, 7'h40, $urandom, 2'd2, "hard_wr");
        tick();
        dmi_hard_reset = 1'b1;
        tick();
        dmi_hard_reset = 1'b0;
        m_pending = 1'b0;
        m_sticky  = 2'd0;
        checkOutput("hard_valid", dmi_req_valid, 0);
        checkOutput("hard_stat", dmi_stat, 0);
        dm_respond(32'hBAD0BAD0, 2'd2);
        run_scan(1, 7'h00, 32'h0, 2'd0, "hard_late");
        checkOutput("hard_hs", hs_count, m_hs);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 16; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = 7'($urandom_range(0, 127));
            r_data = $urandom;
            run_scan(1, r_addr, r_data, r_op, "rnd");
            if (m_pending) begin
                dm_handshake(int'($urandom_range(0, 3)));
                dm_respond($urandom, 2'($urandom_range(0, 3)));
                checkOutput("rnd_stat_rsp", dmi_stat, m_sticky);
            end
            if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1)
                pulse_dmi_reset();
        end
        checkOutput("rnd_hs", hs_count, m_hs);
        if (m_sticky != 2'd0)
            pulse_dmi_reset();

        $display("[TB] async reset mid-shift");
        run_scan(1, 7'h55, $urandom, 2'd2, "arst_wr");
        jtag_sel = 1'b1;
        jtag_capture = 1'b1;
        tick();
        jtag_capture = 1'b0;
        jtag_shift = 1'b1;
        jtag_tdi = 1'b1;
        repeat (5) tick();
        #2 jtag_trst_n = 1'b1;
        #1;
        checkOutput("arst_valid", dmi_req_valid, 0);
        checkOutput("arst_addr", dmi_req_addr, 0);
        checkOutput("arst_data", dmi_req_data, 0);
        checkOutput("arst_op", dmi_req_op, 0);
        checkOutput("arst_stat", dmi_stat, 0);
        checkOutput("arst_tdo", jtag_tdo, 0);
        jtag_trst_n = 1'b0;
        jtag_shift = 1'b0;
        jtag_sel = 1'b0;
        jtag_tdi = 1'b0;
        m_sticky = 2'd0;
        m_pending = 1'b0;
        m_rdata = '0;
        m_last_addr = '0;
        tick();
        run_scan(1, 7'h00, 32'h0, 2'd0, "arst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
